// File: rtl/pid_sched.sv
// Heading PID sequencer: per accepted error sample, computes P, D and I terms
// through one shared signed multiplier and emits a saturated PID correction.
module pid_sched #(
  parameter logic [3:0] P_COEFF = 4'h3,
  parameter logic [4:0] D_COEFF = 5'h0E
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdng_vld,
  input  logic [9:0]  err_sat,
  input  logic        clr_int,
  output logic        busy,
  output logic        ovr,
  output logic [13:0] P_term,
  output logic [12:0] D_term,
  output logic [11:0] I_term,
  output logic [13:0] PID,
  output logic        pid_vld
);

  // Handshake: a sample is taken when hdng_vld is high at a posedge while
  // IDLE; when busy it is dropped and ovr pulses for the following cycle.
  typedef enum logic [1:0] {IDLE, MUL_P, MUL_D, SUM} state_t;

  state_t              state, state_nxt;
  logic                accept;
  logic signed [9:0]   err_cap, prev_err, prev_base;
  logic signed [7:0]   diff;
  logic signed [15:0]  integrator, integ_base;
  logic signed [10:0]  diff_full;
  logic signed [16:0]  integ_sum;
  logic signed [15:0]  pid_sum;
  logic signed [9:0]   mul_a;
  logic signed [5:0]   mul_b;
  logic signed [15:0]  product;

  function automatic logic [7:0] sat8(input logic signed [10:0] v);
    if (v > 11'sd127)       return 8'h7F;
    else if (v < -11'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  function automatic logic [15:0] sat16(input logic signed [16:0] v);
    if (v > 17'sd32767)       return 16'h7FFF;
    else if (v < -17'sd32768) return 16'h8000;
    else                      return v[15:0];
  endfunction

  function automatic logic [13:0] sat14(input logic signed [15:0] v);
    if (v > 16'sd8191)       return 14'h1FFF;
    else if (v < -16'sd8192) return 14'h2000;
    else                     return v[13:0];
  endfunction

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (hdng_vld) begin
          accept    = 1'b1;
          state_nxt = MUL_P;
        end
      end
      MUL_P:   state_nxt = MUL_D;
      MUL_D:   state_nxt = SUM;
      SUM:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Single shared multiplier; operands selected purely by state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_P: begin
        mul_a = err_cap;
        mul_b = {2'b00, P_COEFF};
      end
      MUL_D: begin
        mul_a = {{2{diff[7]}}, diff};
        mul_b = {1'b0, D_COEFF};
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
  end

  assign product = 16'(mul_a) * 16'(mul_b);

  // clr_int wins over the accumulate: the accepted sample sees a zeroed history.
  assign prev_base  = clr_int ? 10'sd0 : prev_err;
  assign integ_base = clr_int ? 16'sd0 : integrator;
  assign diff_full  = {err_sat[9], err_sat} - {prev_base[9], prev_base};
  assign integ_sum  = {integ_base[15], integ_base} + {{7{err_sat[9]}}, err_sat};
  assign pid_sum    = {{2{P_term[13]}}, P_term} + {{3{D_term[12]}}, D_term}
                    + {{4{integrator[15]}}, integrator[15:4]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      err_cap    <= '0;
      prev_err   <= '0;
      diff       <= '0;
      integrator <= '0;
      P_term     <= '0;
      D_term     <= '0;
      I_term     <= '0;
      PID        <= '0;
      busy       <= 1'b0;
      ovr        <= 1'b0;
      pid_vld    <= 1'b0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      ovr     <= hdng_vld && (state != IDLE);
      pid_vld <= (state == SUM);

      if (accept) begin
        err_cap    <= err_sat;
        diff       <= sat8(diff_full);
        prev_err   <= err_sat;
        integrator <= sat16(integ_sum);
      end else if (clr_int) begin
        integrator <= '0;
        prev_err   <= '0;
      end

      case (state)
        MUL_P: P_term <= product[13:0];
        MUL_D: D_term <= product[12:0];
        SUM: begin
          I_term <= integrator[15:4];
          PID    <= sat14(pid_sum);
        end
        default: ;
      endcase
    end
  end

endmodule
